// File: rtl/game_flow_fsm.sv
// rtl/game_flow_fsm.sv - game flow controller: start, levels, lives, win and game-over screens
module game_flow_fsm #(
    parameter int         NUM_LEVELS  = 2,
    parameter int         SEL_W       = 2,
    parameter int         NUM_KEYS    = 4,
    parameter logic [7:0] START_KEY   = 8'h28,
    parameter int         MAX_LIVES   = 3,
    parameter int         LIVES_W     = 2,
    parameter int         PREP_CYCLES = 1
) (
    input  logic                  pixel_clk,
    input  logic                  reset_n,
    input  logic [8*NUM_KEYS-1:0] keycode,
    input  logic                  win_level,
    input  logic                  lose_level,
    output logic [3:0]            game_state,
    output logic [SEL_W-1:0]      level_sel,
    output logic [LIVES_W-1:0]    lives
);

    localparam int PREP_W = (PREP_CYCLES > 1) ? $clog2(PREP_CYCLES) : 1;
    localparam logic [PREP_W-1:0]  PREP_LAST  = PREP_W'(PREP_CYCLES - 1);
    localparam logic [SEL_W-1:0]   LAST_LEVEL = SEL_W'(NUM_LEVELS - 1);
    localparam logic [LIVES_W-1:0] LIVES_INIT = LIVES_W'(MAX_LIVES);

    typedef enum logic [2:0] {
        ST_START     = 3'd0,
        ST_PREP      = 3'd1,
        ST_PLAY      = 3'd2,
        ST_LOSE      = 3'd3,
        ST_WIN       = 3'd4,
        ST_GAME_OVER = 3'd5,
        ST_RELEASE   = 3'd6
    } state_t;

    state_t              state, state_next;
    logic [SEL_W-1:0]    level;
    logic [LIVES_W-1:0]  lives_q;
    logic [PREP_W-1:0]   prep_cnt;
    logic                key_held, key_prev, key_press;
    logic                load_game, level_inc, lives_dec, prep_clr, prep_inc;

    // Start key is held when any keycode slot carries it
    always_comb begin
        key_held = 1'b0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            if (keycode[8*i +: 8] == START_KEY) begin
                key_held = 1'b1;
            end
        end
    end

    assign key_press = key_held & ~key_prev;

    // State register; key_prev resets high so a key held through reset is not a press
    always_ff @(posedge pixel_clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_START;
            key_prev <= 1'b1;
        end else begin
            state    <= state_next;
            key_prev <= key_held;
        end
    end

    // Next-state and datapath control decode
    always_comb begin
        state_next = state;
        load_game  = 1'b0;
        level_inc  = 1'b0;
        lives_dec  = 1'b0;
        prep_clr   = 1'b0;
        prep_inc   = 1'b0;
        case (state)
            ST_START: begin
                if (key_press) begin
                    load_game  = 1'b1;
                    prep_clr   = 1'b1;
                    state_next = ST_PREP;
                end
            end
            ST_PREP: begin
                if (prep_cnt < PREP_LAST) begin
                    prep_inc = 1'b1;
                end else begin
                    state_next = ST_PLAY;
                end
            end
            ST_PLAY: begin
                if (win_level) begin
                    if (level == LAST_LEVEL) begin
                        state_next = ST_WIN;
                    end else begin
                        level_inc  = 1'b1;
                        prep_clr   = 1'b1;
                        state_next = ST_PREP;
                    end
                end else if (lose_level) begin
                    state_next = ST_LOSE;
                end
            end
            ST_LOSE: begin
                lives_dec = (lives_q != '0);
                if (lives_q <= LIVES_W'(1)) begin
                    state_next = ST_GAME_OVER;
                end else begin
                    prep_clr   = 1'b1;
                    state_next = ST_PREP;
                end
            end
            ST_WIN, ST_GAME_OVER: begin
                if (key_press) begin
                    state_next = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                if (!key_held) begin
                    state_next = ST_START;
                end
            end
            default: state_next = ST_START;
        endcase
    end

    // Level, lives and prep counter registers
    always_ff @(posedge pixel_clk or negedge reset_n) begin
        if (!reset_n) begin
            level    <= '0;
            lives_q  <= LIVES_INIT;
            prep_cnt <= '0;
        end else begin
            if (load_game) begin
                level   <= '0;
                lives_q <= LIVES_INIT;
            end else begin
                if (level_inc) level   <= level + SEL_W'(1);
                if (lives_dec) lives_q <= lives_q - LIVES_W'(1);
            end
            if (prep_clr) begin
                prep_cnt <= '0;
            end else if (prep_inc) begin
                prep_cnt <= prep_cnt + PREP_W'(1);
            end
        end
    end

    // Moore output decode from registered state, level and lives
    always_comb begin
        game_state = 4'd0;
        level_sel  = '0;
        case (state)
            ST_START:     game_state = 4'd0;
            ST_PREP:      begin game_state = 4'd1; level_sel = level; end
            ST_LOSE:      begin game_state = 4'd1; level_sel = level; end
            ST_RELEASE:   game_state = 4'd1;
            ST_PLAY:      begin game_state = 4'd2; level_sel = level; end
            ST_WIN:       game_state = 4'd3;
            ST_GAME_OVER: game_state = 4'd4;
            default:      game_state = 4'd0;
        endcase
    end

    assign lives = lives_q;

endmodule

// File: tb/tb_game_flow_fsm.sv
// tb/tb_game_flow_fsm.sv - self-checking bench for game_flow_fsm
module tb_game_flow_fsm;

    localparam int NLEV  = 3;
    localparam int NPREP = 4;
    localparam int NLIV  = 3;
    localparam logic [31:0] K0 = 32'h0000_0028;
    localparam logic [31:0] K1 = 32'h0000_2800;
    localparam logic [31:0] K2 = 32'h0028_0000;
    localparam logic [31:0] K3 = 32'h2800_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] keys;
    logic        win, lose;
    logic [3:0]  gs;
    logic [1:0]  lvl;
    logic [1:0]  lv;

    int n_cmp  = 0;
    int n_fail = 0;

    game_flow_fsm #(
        .NUM_LEVELS(NLEV), .SEL_W(2), .NUM_KEYS(4), .START_KEY(8'h28),
        .MAX_LIVES(NLIV), .LIVES_W(2), .PREP_CYCLES(NPREP)
    ) dut (
        .pixel_clk(clk), .reset_n(rst_n), .keycode(keys),
        .win_level(win), .lose_level(lose),
        .game_state(gs), .level_sel(lvl), .lives(lv)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] k;
        logic        w;
        logic        l;
        int          egs;
        int          elvl;
        int          elv;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic [31:0] k, logic w, logic l, int egs, int elvl, int elv);
        vec_t v;
        v.k = k; v.w = w; v.l = l; v.egs = egs; v.elvl = elvl; v.elv = elv;
        return v;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_out(input string name, input int egs, input int elvl, input int elv);
        check({name, ".game_state"}, int'(gs), egs);
        check({name, ".level_sel"}, int'(lvl), elvl);
        check({name, ".lives"}, int'(lv), elv);
    endtask

    // drive at negedge, let one rising edge pass, sample at the next negedge
    task automatic step(input logic [31:0] k, input logic w, input logic l,
                        input int egs, input int elvl, input int elv, input string name);
        keys = k; win = w; lose = l;
        @(posedge clk);
        @(negedge clk);
        check_out(name, egs, elvl, elv);
    endtask

    // Reference model: screens tracked as named phases with a PREP countdown
    localparam int M_START = 0, M_PREP = 1, M_PLAY = 2, M_LOSE = 3,
                   M_WIN = 4, M_OVER = 5, M_REL = 6;
    int m_mode, m_level, m_lives, m_prep_left;
    bit m_prev;

    function automatic void model_reset();
        m_mode = M_START; m_level = 0; m_lives = NLIV; m_prep_left = 0; m_prev = 1'b1;
    endfunction

    function automatic void model_step(logic [31:0] k, logic w, logic l);
        bit held  = 1'b0;
        bit press;
        for (int i = 0; i < 4; i++) if (k[8*i +: 8] == 8'h28) held = 1'b1;
        press  = held && !m_prev;
        m_prev = held;
        case (m_mode)
            M_START: if (press) begin
                m_lives = NLIV; m_level = 0; m_mode = M_PREP; m_prep_left = NPREP;
            end
            M_PREP: begin
                m_prep_left--;
                if (m_prep_left == 0) m_mode = M_PLAY;
            end
            M_PLAY: begin
                if (w) begin
                    if (m_level == NLEV - 1) m_mode = M_WIN;
                    else begin m_level++; m_mode = M_PREP; m_prep_left = NPREP; end
                end else if (l) m_mode = M_LOSE;
            end
            M_LOSE: begin
                m_lives--;
                if (m_lives == 0) m_mode = M_OVER;
                else begin m_mode = M_PREP; m_prep_left = NPREP; end
            end
            M_WIN, M_OVER: if (press) m_mode = M_REL;
            M_REL: if (!held) m_mode = M_START;
            default: m_mode = M_START;
        endcase
    endfunction

    function automatic int model_gs();
        case (m_mode)
            M_START: return 0;
            M_PLAY:  return 2;
            M_WIN:   return 3;
            M_OVER:  return 4;
            default: return 1;
        endcase
    endfunction

    function automatic int model_lvl();
        return (m_mode == M_PREP || m_mode == M_PLAY || m_mode == M_LOSE) ? m_level : 0;
    endfunction

    initial begin
        rst_n = 1'b0; keys = K3; win = 1'b0; lose = 1'b0;
        repeat (2) @(negedge clk);
        check_out("reset", 0, 0, 3);
        rst_n = 1'b1;

        // start sequence, two levels, lose path to game over, restart
        vecs.push_back(mk(K3, 0, 0, 0, 0, 3));
        vecs.push_back(mk(0,  0, 0, 0, 0, 3));
        vecs.push_back(mk(K0, 0, 0, 1, 0, 3));
        vecs.push_back(mk(K0, 0, 0, 1, 0, 3));
        vecs.push_back(mk(0,  0, 0, 1, 0, 3));
        vecs.push_back(mk(0,  0, 0, 1, 0, 3));
        vecs.push_back(mk(0,  0, 0, 2, 0, 3));
        vecs.push_back(mk(0,  1, 1, 1, 1, 3));
        vecs.push_back(mk(0,  1, 0, 1, 1, 3));
        vecs.push_back(mk(0,  0, 1, 1, 1, 3));
        vecs.push_back(mk(0,  0, 0, 1, 1, 3));
        vecs.push_back(mk(0,  0, 0, 2, 1, 3));
        vecs.push_back(mk(K0, 0, 1, 1, 1, 3));
        vecs.push_back(mk(0,  0, 0, 1, 1, 2));
        vecs.push_back(mk(0,  0, 0, 1, 1, 2));
        vecs.push_back(mk(0,  0, 0, 1, 1, 2));
        vecs.push_back(mk(0,  0, 0, 1, 1, 2));
        vecs.push_back(mk(0,  0, 0, 2, 1, 2));
        vecs.push_back(mk(0,  0, 1, 1, 1, 2));
        vecs.push_back(mk(0,  0, 0, 1, 1, 1));
        vecs.push_back(mk(0,  0, 0, 1, 1, 1));
        vecs.push_back(mk(0,  0, 0, 1, 1, 1));
        vecs.push_back(mk(0,  0, 0, 1, 1, 1));
        vecs.push_back(mk(0,  0, 0, 2, 1, 1));
        vecs.push_back(mk(0,  0, 1, 1, 1, 1));
        vecs.push_back(mk(0,  0, 0, 4, 0, 0));
        vecs.push_back(mk(0,  1, 1, 4, 0, 0));
        vecs.push_back(mk(K1, 0, 0, 1, 0, 0));
        vecs.push_back(mk(K1, 0, 0, 1, 0, 0));
        vecs.push_back(mk(0,  0, 0, 0, 0, 0));
        vecs.push_back(mk(K2, 0, 0, 1, 0, 3));
        vecs.push_back(mk(0,  0, 0, 1, 0, 3));
        vecs.push_back(mk(0,  0, 0, 1, 0, 3));
        vecs.push_back(mk(0,  0, 0, 1, 0, 3));
        vecs.push_back(mk(0,  0, 0, 2, 0, 3));
        foreach (vecs[i]) begin
            step(vecs[i].k, vecs[i].w, vecs[i].l, vecs[i].egs, vecs[i].elvl, vecs[i].elv,
                 $sformatf("vec%0d", i));
        end

        // win every level, then key held across WIN entry, then 10-cycle hold in RELEASE
        for (int lv_i = 0; lv_i < NLEV - 1; lv_i++) begin
            step(0, 1, 0, 1, lv_i + 1, 3, $sformatf("win%0d", lv_i));
            for (int c = 1; c < NPREP; c++) step(0, 0, 0, 1, lv_i + 1, 3, $sformatf("prep%0d", lv_i));
            step(0, 0, 0, 2, lv_i + 1, 3, $sformatf("play%0d", lv_i));
        end
        step(K0, 1, 0, 3, 0, 3, "final_win");
        for (int c = 0; c < 3; c++) step(K0, 0, 0, 3, 0, 3, "win_held");
        step(0, 0, 0, 3, 0, 3, "win_idle");
        for (int c = 0; c < 10; c++) step(K3, 0, 0, 1, 0, 3, "release_hold");
        step(0, 0, 0, 0, 0, 3, "back_to_start");
        step(K0, 0, 0, 1, 0, 3, "restart");
        for (int c = 1; c < NPREP; c++) step(0, 0, 0, 1, 0, 3, "restart_prep");
        step(0, 0, 0, 2, 0, 3, "restart_play");

        // reach mid-PREP at level 1 with one life, then reset asynchronously
        step(0, 1, 0, 1, 1, 3, "r_win");
        for (int c = 1; c < NPREP; c++) step(0, 0, 0, 1, 1, 3, "r_prep");
        step(0, 0, 0, 2, 1, 3, "r_play");
        step(0, 0, 1, 1, 1, 3, "r_lose1");
        for (int c = 0; c < NPREP; c++) step(0, 0, 0, 1, 1, 2, "r_prep2");
        step(0, 0, 0, 2, 1, 2, "r_play2");
        step(0, 0, 1, 1, 1, 2, "r_lose2");
        step(0, 0, 0, 1, 1, 1, "r_prep3a");
        step(0, 0, 0, 1, 1, 1, "r_prep3b");
        rst_n = 1'b0;
        #1;
        check_out("async_reset", 0, 0, 3);
        @(negedge clk);
        rst_n = 1'b1;

        // randomized run against the reference model
        model_reset();
        for (int cyc = 0; cyc < 4000; cyc++) begin
            logic [31:0] k;
            logic w, l;
            case ($urandom_range(0, 2))
                0:       k = 32'h28 << (8 * $urandom_range(0, 3));
                1:       k = 32'h0;
                default: k = $urandom;
            endcase
            if (cyc % 40 >= 30) k = 32'h0;
            w = ($urandom_range(0, 4) == 0);
            l = ($urandom_range(0, 3) == 0);
            keys = k; win = w; lose = l;
            @(posedge clk);
            model_step(k, w, l);
            @(negedge clk);
            check_out("rand", model_gs(), model_lvl(), m_lives);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
